// File: rtl/rpn_pkg.sv
// Shared types and flag bit positions for the reverse-polish calculator datapath.
package rpn_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } opcode_t;

    typedef enum logic {
        DISP_INPUT  = 1'b0,
        DISP_RESULT = 1'b1
    } disp_mode_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU: add/sub/and/or with {N,Z,C,V} flags; results wrap at WIDTH bits.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  opcode_t          opcode,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           ovf;

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    // the extra top bit of the widened difference is the unsigned borrow
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:  result = op_a & op_b;
            default: result = op_a | op_b;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/rpn_datapath.sv
// Operand/result registers behind the RPN control FSM, plus the display-mode latch
// that stretches the one-cycle Show_Result pulse into a persistent result display.
//
// state       | meaning
// DISP_INPUT  | display echoes the switch bus
// DISP_RESULT | display holds the captured result until the next operand A load
module rpn_datapath
    import rpn_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int OPCODE_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_Data,
    input  logic             in_LoadOpA,
    input  logic             in_LoadOpB,
    input  logic             in_LoadOpCode,
    input  logic             in_updateRes,
    input  logic             in_ToDisplaySel,
    output logic [WIDTH-1:0] out_Display,
    output logic [3:0]       out_Flags,
    output logic             out_ResultShown
);

    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic [OPCODE_W-1:0] op_code;
    logic [WIDTH-1:0]    result;
    logic [3:0]          flags;
    logic [WIDTH-1:0]    alu_result;
    logic [3:0]          alu_flags;
    disp_mode_t          mode;
    disp_mode_t          mode_next;

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .op_a   (op_a),
        .op_b   (op_b),
        .opcode (opcode_t'(op_code)),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a    <= '0;
            op_b    <= '0;
            op_code <= '0;
            result  <= '0;
            flags   <= '0;
        end else begin
            if (in_LoadOpA)    op_a    <= in_Data;
            if (in_LoadOpB)    op_b    <= in_Data;
            if (in_LoadOpCode) op_code <= in_Data[OPCODE_W-1:0];
            if (in_updateRes || in_ToDisplaySel) begin
                result <= alu_result;
                flags  <= alu_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mode <= DISP_INPUT;
        else        mode <= mode_next;
    end

    // Show_Result takes priority over a simultaneous operand A load
    always_comb begin
        mode_next = mode;
        if (in_ToDisplaySel)  mode_next = DISP_RESULT;
        else if (in_LoadOpA)  mode_next = DISP_INPUT;
    end

    always_comb begin
        out_ResultShown = (mode == DISP_RESULT);
        out_Display     = out_ResultShown ? result : in_Data;
        out_Flags       = flags;
    end

endmodule

// File: doc/rpn_datapath.md
Name: rpn_datapath

Overview:
- Operand/result datapath directly downstream of the reverse-polish control FSM.
- Captures operand A, operand B and the opcode from the switch bus on the FSM's single-cycle load strobes.
- Computes the ALU result and registers it with flags.
- Holds the value to be shown on the 7-segment/LED display, so the FSM's one-cycle Show_Result pulse is stretched into a persistent result display.

Parameters:
- WIDTH, 16, operand/result width in bits (min 4).
- OPCODE_W, 2, opcode field width, taken from in_Data[OPCODE_W-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_Data  in  WIDTH  switch bus; operand or opcode being entered.
- in_LoadOpA  in  1  one-cycle strobe: capture in_Data into OpA.
- in_LoadOpB  in  1  one-cycle strobe: capture in_Data into OpB.
- in_LoadOpCode  in  1  one-cycle strobe: capture in_Data[OPCODE_W-1:0] into OpCode.
- in_updateRes  in  1  one-cycle strobe: capture ALU result and flags.
- in_ToDisplaySel  in  1  one-cycle strobe: capture result and switch display to result mode.
- out_Display  out  WIDTH  value for display driver.
- out_Flags  out  4  registered {N,Z,C,V} of last captured result.
- out_ResultShown  out  1  1 while display is in result mode.

Behaviour:
- Reset (reset=0, async): OpA, OpB, OpCode, Result, Flags and mode all clear to 0.
  - out_Display = in_Data (input mode).
  - out_Flags = 4'b0000.
  - out_ResultShown = 0.
- Reset release is synchronous to clk (2-FF synchroniser on deassert is out of scope; the top level provides it).
- Operand registers:
  - Each load strobe updates only its own register, at the edge where the strobe is 1.
  - Registers otherwise hold their value.
  - If several load strobes are active in one cycle, all of them take effect (independent registers; the FSM never does this).
- ALU: combinational on registered OpA, OpB, OpCode.
  - 00 ADD: OpA+OpB; C = carry out; V = signed overflow.
  - 01 SUB: OpA-OpB; C = borrow (1 when OpA<OpB unsigned); V = signed overflow.
  - 10 AND: C = V = 0.
  - 11 OR: C = V = 0.
  - N = Result[WIDTH-1]; Z = (Result == 0).
  - All results are truncated to WIDTH bits (wrap-around, no saturation).
- Result capture:
  - At an edge where (in_updateRes | in_ToDisplaySel) = 1, Result and Flags load the ALU output.
  - Latency from in_LoadOpCode to a valid ALU output is 1 cycle. The capture strobe arriving in the following cycle (Show_Result) sees the new opcode.
- Display mode: one-bit state machine, INPUT and RESULT.
  - INPUT -> RESULT at an edge with in_ToDisplaySel = 1.
  - RESULT -> INPUT at an edge with in_LoadOpA = 1.
  - If in_ToDisplaySel and in_LoadOpA are both 1, in_ToDisplaySel wins (stay/enter RESULT).
  - INPUT: out_Display = in_Data (combinational echo of switches).
  - RESULT: out_Display = Result register.
  - out_ResultShown = (mode == RESULT).
  - The FSM's Undo path never pulses in_LoadOpA, so an undo leaves the display mode unchanged.
- in_updateRes alone updates Result and Flags without changing mode. In INPUT mode the update is invisible until the next in_ToDisplaySel.
- Asserting reset mid-sequence discards all registers immediately; the next result needs a full new OpA/OpB/OpCode sequence.

Decomposition:
- Package rpn_pkg:
  - opcode_t enum {OP_ADD, OP_SUB, OP_AND, OP_OR}.
  - disp_mode_t enum {DISP_INPUT, DISP_RESULT}.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module rpn_alu, parameterised by WIDTH: inputs OpA, OpB, opcode; outputs result and flags.
- rpn_datapath holds all registers and the display-mode FSM.

Test Plan (WIDTH=16):
- Reset, then in_Data=16'h1234 -> out_Display=16'h1234, out_Flags=0, out_ResultShown=0. Assert reset mid-sequence -> same outputs immediately, without waiting for a clock edge.
- Load A=16'h0005, B=16'h0003, op=00, pulse ToDisplaySel one cycle later -> out_Display=16'h0008, Flags=0000, ResultShown=1. Change in_Data afterwards -> out_Display stays 16'h0008.
- A=16'h7FFF, B=16'h0001, ADD -> 16'h8000, Flags N=1 Z=0 C=0 V=1. A=16'hFFFF, B=16'h0001, ADD -> 16'h0000, Flags N=0 Z=1 C=1 V=0.
- A=16'h0003, B=16'h0005, SUB -> 16'hFFFE, Flags N=1 Z=0 C=1 V=0. A=16'hF0F0, B=16'h0FF0: AND -> 16'h00F0; OR -> 16'hFFF0, C=V=0.
- In RESULT mode pulse in_LoadOpA with in_Data=16'h00AA -> next cycle ResultShown=0, out_Display=in_Data. Pulse LoadOpA and ToDisplaySel in the same cycle -> ResultShown=1.
- Pulse in_updateRes alone in INPUT mode -> Flags update, out_Display still equals in_Data, ResultShown=0.
